// File: rtl/cache_pkg.sv
// Shared types and widths for the L1 cache slice.
package cache_pkg;

    localparam int WORD_W  = 32;
    localparam int LINE_W  = 128;
    localparam int PADDR_W = 30;
    localparam int MADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    // Select one 32-bit word from a line; word 0 sits in the low bits.
    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_storage.sv
// Valid/dirty/tag/data arrays for a direct-mapped cache: one indexed read
// port, a single-word write port and a full-line fill port.
module cache_storage
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX        = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = MADDR_W - IDX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX-1:0]    rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX-1:0]    wr_idx,
    input  logic [1:0]        wr_off,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              fill_en,
    input  logic [IDX-1:0]    fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

    // Status bits: cleared on reset, fill makes a line valid and clean,
    // a word write marks it dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: not reset, a line is only trusted once valid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end else if (wr_en) begin
            data_q[wr_idx][wr_off*WORD_W +: WORD_W] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with a block-wide
// handshake to main memory for writebacks and fills.
module l1_cache
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               proc_ren,
    input  logic               proc_wen,
    input  logic [PADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0]  proc_wdata,
    output logic               proc_stall,
    output logic [WORD_W-1:0]  proc_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [MADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic               mem_ready,
    input  logic [LINE_W-1:0]  mem_rdata
);

    localparam int IDX   = $clog2(NUM_BLOCKS);
    localparam int TAG_W = MADDR_W - IDX;

    logic [1:0]        req_off;
    logic [IDX-1:0]    req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req;
    logic              hit;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;

    logic              word_we;
    logic              fill_en;

    state_t state_q, state_d;

    assign req_off = proc_addr[1:0];
    assign req_idx = proc_addr[IDX+1:2];
    assign req_tag = proc_addr[PADDR_W-1:IDX+2];
    assign req     = proc_ren | proc_wen;
    assign hit     = rd_valid && (rd_tag == req_tag);

    cache_storage #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (req_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (word_we),
        .wr_idx    (req_idx),
        .wr_off    (req_off),
        .wr_data   (proc_wdata),
        .fill_en   (fill_en),
        .fill_idx  (req_idx),
        .fill_tag  (req_tag),
        .fill_line (mem_rdata)
    );

    // Read data always shows the indexed word; only meaningful on a read hit.
    assign proc_rdata = get_word(rd_line, req_off);

    // State register; reset aborts any miss in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and outputs; memory strobes depend on the state register only.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        word_we = proc_wen;
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, req_idx};
                mem_wdata  = rd_line;
                if (mem_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {req_tag, req_idx};
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_cache.sv
// Directed-vector bench for l1_cache: misses, hits, writeback, reset abort.
module tb_l1_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_ren;
    logic         proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int vectors;
    int errors;
    int stalls;

    localparam logic [127:0] FILL1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] FILL2 = 128'h0000_000D_0000_000C_0000_000B_0000_000A;
    localparam logic [127:0] FILL3 = 128'h0000_0044_0000_0033_0000_0022_0000_0011;

    l1_cache #(
        .NUM_BLOCKS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_ren   (proc_ren),
        .proc_wen   (proc_wen),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        stalls     = 0;
        rst_n      = 1'b0;
        proc_ren   = 1'b0;
        proc_wen   = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_stall", proc_stall, 0);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        tick();
        rst_n = 1'b1;

        // Clean miss on 0x10, fill returned in the first ALLOCATE cycle
        tick();
        proc_ren  = 1'b1;
        proc_addr = 30'h10;
        @(negedge clk);
        check_eq("miss_stall", proc_stall, 1);
        check_eq("miss_idle_no_read", mem_read, 0);
        stalls += int'(proc_stall);
        tick();
        mem_ready = 1'b1;
        mem_rdata = FILL1;
        @(negedge clk);
        check_eq("alloc_mem_read", mem_read, 1);
        check_eq("alloc_mem_write", mem_write, 0);
        check_eq("alloc_mem_addr", mem_addr, 28'h4);
        stalls += int'(proc_stall);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("fill_stall", proc_stall, 0);
        check_eq("fill_rdata", proc_rdata, 32'h1111_1111);
        check_eq("fill_mem_read_drop", mem_read, 0);
        check_eq("clean_miss_stalls", stalls, 2);

        // Read hit on another word of the same line
        tick();
        proc_addr = 30'h13;
        @(negedge clk);
        check_eq("hit_stall", proc_stall, 0);
        check_eq("hit_rdata", proc_rdata, 32'h4444_4444);
        check_eq("hit_no_mem", {mem_read, mem_write}, 0);

        // Write hit then read back
        tick();
        proc_ren   = 1'b0;
        proc_wen   = 1'b1;
        proc_addr  = 30'h11;
        proc_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("whit_stall", proc_stall, 0);
        tick();
        proc_wen = 1'b0;
        proc_ren = 1'b1;
        @(negedge clk);
        check_eq("whit_readback", proc_rdata, 32'hDEAD_BEEF);
        check_eq("whit_rb_stall", proc_stall, 0);
        tick();
        proc_addr = 30'h10;
        @(negedge clk);
        check_eq("whit_word0_kept", proc_rdata, 32'h1111_1111);

        // mem_ready while idle is ignored
        tick();
        proc_ren  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_ready_stall", proc_stall, 0);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_ready_ignored", {mem_read, mem_write}, 0);

        // Conflicting read on index 4 forces writeback of the dirty line
        tick();
        proc_ren  = 1'b1;
        proc_addr = 30'h30;
        @(negedge clk);
        check_eq("conf_stall", proc_stall, 1);
        check_eq("conf_idle_no_write", mem_write, 0);
        tick();
        @(negedge clk);
        check_eq("wb_mem_write", mem_write, 1);
        check_eq("wb_mem_read", mem_read, 0);
        check_eq("wb_mem_addr", mem_addr, 28'h4);
        check_eq("wb_word1", mem_wdata[63:32], 32'hDEAD_BEEF);
        check_eq("wb_word0", mem_wdata[31:0], 32'h1111_1111);
        check_eq("wb_stall", proc_stall, 1);
        tick();
        @(negedge clk);
        check_eq("wb_held", mem_write, 1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = FILL3;
        @(negedge clk);
        check_eq("wb_ready_cycle", mem_write, 1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("wb2alloc_read", mem_read, 1);
        check_eq("wb2alloc_write", mem_write, 0);
        check_eq("wb2alloc_addr", mem_addr, 28'hC);
        tick();
        @(negedge clk);
        check_eq("alloc_held", mem_read, 1);

        // Asynchronous reset in the middle of ALLOCATE
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_mem_read", mem_read, 0);
        check_eq("rstmid_mem_write", mem_write, 0);
        check_eq("rstmid_mem_addr", mem_addr, 0);
        tick();
        rst_n     = 1'b1;
        proc_addr = 30'h11;
        @(negedge clk);
        check_eq("post_rst_miss", proc_stall, 1);
        tick();
        @(negedge clk);
        check_eq("post_rst_mem_read", mem_read, 1);
        check_eq("post_rst_mem_addr", mem_addr, 28'h4);
        tick();
        mem_ready = 1'b1;
        mem_rdata = FILL2;
        @(negedge clk);
        check_eq("post_rst_wait", proc_stall, 1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("post_rst_rdata", proc_rdata, 32'h0000_000B);
        check_eq("post_rst_done", proc_stall, 0);

        // ren and wen together on a clean hit: write wins and sets dirty
        tick();
        proc_wen   = 1'b1;
        proc_wdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("rw_stall", proc_stall, 0);
        tick();
        proc_wen = 1'b0;
        @(negedge clk);
        check_eq("rw_readback", proc_rdata, 32'h1234_5678);

        // Dirty miss with immediate ready in both phases: 3 stall cycles
        tick();
        proc_addr = 30'h31;
        stalls    = 0;
        @(negedge clk);
        check_eq("dmiss_stall", proc_stall, 1);
        stalls += int'(proc_stall);
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("dmiss_wb", mem_write, 1);
        check_eq("dmiss_wb_addr", mem_addr, 28'h4);
        check_eq("dmiss_wb_word1", mem_wdata[63:32], 32'h1234_5678);
        check_eq("dmiss_wb_word0", mem_wdata[31:0], 32'h0000_000A);
        stalls += int'(proc_stall);
        tick();
        mem_rdata = FILL3;
        @(negedge clk);
        check_eq("dmiss_alloc_read", mem_read, 1);
        check_eq("dmiss_alloc_write", mem_write, 0);
        check_eq("dmiss_alloc_addr", mem_addr, 28'hC);
        stalls += int'(proc_stall);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("dmiss_done", proc_stall, 0);
        check_eq("dmiss_rdata", proc_rdata, 32'h0000_0022);
        check_eq("dmiss_stalls", stalls, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
